// File: rtl/bmp_pkg.sv
// Shared types and constants for the BMP pixel streamer.
package bmp_pkg;

   typedef enum logic [2:0] {
      ST_HDR  = 3'd0,
      ST_SKIP = 3'd1,
      ST_PIX  = 3'd2,
      ST_PAD  = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_e;

   // Byte positions inside the BMP file/info headers
   localparam int unsigned IDX_OFFSET = 10;
   localparam int unsigned IDX_WIDTH  = 18;
   localparam int unsigned IDX_HEIGHT = 22;
   localparam int unsigned IDX_BPP    = 28;
   localparam int unsigned HDR_LEN    = 30;

   localparam logic [7:0]  SIG_B  = 8'h42;
   localparam logic [7:0]  SIG_M  = 8'h4D;
   localparam logic [15:0] BPP_24 = 16'd24;

   // Replace one byte lane of a little-endian 32-bit word
   function automatic logic [31:0] put_byte(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  b);
      logic [31:0] res;
      res = word;
      case (lane)
         2'd0:    res[7:0]   = b;
         2'd1:    res[15:8]  = b;
         2'd2:    res[23:16] = b;
         default: res[31:24] = b;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/bmp_pixel_stream.sv
// Parses a 24-bit BMP byte stream into a header summary and a BGR pixel stream.
module bmp_pixel_stream
   import bmp_pkg::*;
#(
   parameter bit CHECK_BPP = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        px_valid,
   input  logic        px_ready,
   output logic [7:0]  px_b,
   output logic [7:0]  px_g,
   output logic [7:0]  px_r,
   output logic        px_last,
   output logic [31:0] offset,
   output logic [31:0] width,
   output logic [31:0] height,
   output logic        hdr_valid,
   output logic        done,
   output logic        err
);

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] col_q, col_d;
   logic [31:0] row_q, row_d;
   logic [1:0]  phase_q, phase_d;
   logic [1:0]  pad_cnt_q, pad_cnt_d;
   logic [7:0]  sig0_q, sig0_d, sig1_q, sig1_d, bpp_lo_q, bpp_lo_d;
   logic [31:0] offset_q, offset_d, width_q, width_d, height_q, height_d;
   logic [7:0]  px_b_q, px_b_d, px_g_q, px_g_d, px_r_q, px_r_d;
   logic        px_valid_q, px_valid_d, px_last_q, px_last_d;
   logic        hdr_valid_q, hdr_valid_d, done_q, done_d, err_q, err_d;

   logic        accept;
   logic        hdr_bad;
   logic        zero_dim;
   logic        last_col;
   logic        last_row;
   logic [1:0]  pad;
   logic [1:0]  lane;

   // Hold the byte stream while a pixel stalls, and stop before the final row's padding
   assign in_ready = (state_q != ST_DONE) && (state_q != ST_ERR) &&
                     !(px_valid_q && (!px_ready || px_last_q));
   assign accept   = in_valid && in_ready;
   assign pad      = width_q[1:0];
   // All three 32-bit fields start 2 mod 4, so one lane index serves them all
   assign lane     = 2'(cnt_q - 32'(IDX_OFFSET));
   assign zero_dim = (width_q == 32'd0) || (height_q == 32'd0);
   assign last_col = (col_q == width_q - 32'd1);
   assign last_row = (row_q == height_q - 32'd1);
   assign hdr_bad  = (sig0_q != SIG_B) || (sig1_q != SIG_M) ||
                     (offset_q < 32'(HDR_LEN)) || height_q[31] ||
                     (CHECK_BPP && ({in_data, bpp_lo_q} != BPP_24));

   // Next-state, header capture, pixel assembly and row/column tracking
   always_comb begin
      state_d     = state_q;
      cnt_d       = accept ? cnt_q + 32'd1 : cnt_q;
      col_d       = col_q;
      row_d       = row_q;
      phase_d     = phase_q;
      pad_cnt_d   = pad_cnt_q;
      sig0_d      = sig0_q;
      sig1_d      = sig1_q;
      bpp_lo_d    = bpp_lo_q;
      offset_d    = offset_q;
      width_d     = width_q;
      height_d    = height_q;
      px_b_d      = px_b_q;
      px_g_d      = px_g_q;
      px_r_d      = px_r_q;
      px_valid_d  = px_valid_q && !px_ready;
      px_last_d   = px_last_q && !px_ready;
      hdr_valid_d = hdr_valid_q;

      case (state_q)
         ST_HDR: begin
            if (accept) begin
               if (cnt_q == 32'd0) sig0_d = in_data;
               if (cnt_q == 32'd1) sig1_d = in_data;
               if (cnt_q >= 32'(IDX_OFFSET) && cnt_q < 32'(IDX_OFFSET + 4))
                  offset_d = put_byte(offset_q, lane, in_data);
               if (cnt_q >= 32'(IDX_WIDTH) && cnt_q < 32'(IDX_WIDTH + 4))
                  width_d = put_byte(width_q, lane, in_data);
               if (cnt_q >= 32'(IDX_HEIGHT) && cnt_q < 32'(IDX_HEIGHT + 4))
                  height_d = put_byte(height_q, lane, in_data);
               if (cnt_q == 32'(IDX_BPP)) bpp_lo_d = in_data;
               if (cnt_q == 32'(HDR_LEN - 1)) begin
                  if (hdr_bad) begin
                     state_d = ST_ERR;
                  end else begin
                     hdr_valid_d = 1'b1;
                     if (offset_q == 32'(HDR_LEN))
                        state_d = zero_dim ? ST_DONE : ST_PIX;
                     else
                        state_d = ST_SKIP;
                  end
               end
            end
         end
         ST_SKIP: begin
            if (accept && (cnt_q + 32'd1 == offset_q))
               state_d = zero_dim ? ST_DONE : ST_PIX;
         end
         ST_PIX: begin
            if (accept) begin
               case (phase_q)
                  2'd0: begin
                     px_b_d  = in_data;
                     phase_d = 2'd1;
                  end
                  2'd1: begin
                     px_g_d  = in_data;
                     phase_d = 2'd2;
                  end
                  default: begin
                     px_r_d     = in_data;
                     phase_d    = 2'd0;
                     px_valid_d = 1'b1;
                     px_last_d  = last_row && last_col;
                     if (last_col) begin
                        if (!last_row) begin
                           col_d = 32'd0;
                           row_d = row_q + 32'd1;
                           if (pad != 2'd0) state_d = ST_PAD;
                        end
                     end else begin
                        col_d = col_q + 32'd1;
                     end
                  end
               endcase
            end else if (px_valid_q && px_ready && px_last_q) begin
               state_d = ST_DONE;
            end
         end
         ST_PAD: begin
            if (accept) begin
               if (pad_cnt_q == pad - 2'd1) begin
                  pad_cnt_d = 2'd0;
                  state_d   = ST_PIX;
               end else begin
                  pad_cnt_d = pad_cnt_q + 2'd1;
               end
            end
         end
         default: ;
      endcase

      done_d = (state_d == ST_DONE);
      err_d  = (state_d == ST_ERR);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_HDR;
         cnt_q       <= '0;
         col_q       <= '0;
         row_q       <= '0;
         phase_q     <= '0;
         pad_cnt_q   <= '0;
         sig0_q      <= '0;
         sig1_q      <= '0;
         bpp_lo_q    <= '0;
         offset_q    <= '0;
         width_q     <= '0;
         height_q    <= '0;
         px_b_q      <= '0;
         px_g_q      <= '0;
         px_r_q      <= '0;
         px_valid_q  <= 1'b0;
         px_last_q   <= 1'b0;
         hdr_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         col_q       <= col_d;
         row_q       <= row_d;
         phase_q     <= phase_d;
         pad_cnt_q   <= pad_cnt_d;
         sig0_q      <= sig0_d;
         sig1_q      <= sig1_d;
         bpp_lo_q    <= bpp_lo_d;
         offset_q    <= offset_d;
         width_q     <= width_d;
         height_q    <= height_d;
         px_b_q      <= px_b_d;
         px_g_q      <= px_g_d;
         px_r_q      <= px_r_d;
         px_valid_q  <= px_valid_d;
         px_last_q   <= px_last_d;
         hdr_valid_q <= hdr_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign px_valid  = px_valid_q;
   assign px_last   = px_last_q;
   assign px_b      = px_b_q;
   assign px_g      = px_g_q;
   assign px_r      = px_r_q;
   assign offset    = offset_q;
   assign width     = width_q;
   assign height    = height_q;
   assign hdr_valid = hdr_valid_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bmp_pixel_stream.sv
// Directed bench for bmp_pixel_stream: builds small BMP files and checks the pixel stream.
module tb_bmp_pixel_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        px_ready = 1'b1;

   logic        in_ready, px_valid, px_last, hdr_valid, done, err;
   logic [7:0]  px_b, px_g, px_r;
   logic [31:0] offset, width, height;

   logic        n_in_ready, n_px_valid, n_px_last, n_hdr_valid, n_done, n_err;
   logic [7:0]  n_px_b, n_px_g, n_px_r;
   logic [31:0] n_offset, n_width, n_height;

   bmp_pixel_stream #(.CHECK_BPP(1'b1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .px_valid(px_valid), .px_ready(px_ready), .px_b(px_b), .px_g(px_g), .px_r(px_r),
      .px_last(px_last), .offset(offset), .width(width), .height(height),
      .hdr_valid(hdr_valid), .done(done), .err(err)
   );

   bmp_pixel_stream #(.CHECK_BPP(1'b0)) u_dut_nc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(n_in_ready),
      .px_valid(n_px_valid), .px_ready(px_ready), .px_b(n_px_b), .px_g(n_px_g), .px_r(n_px_r),
      .px_last(n_px_last), .offset(n_offset), .width(n_width), .height(n_height),
      .hdr_valid(n_hdr_valid), .done(n_done), .err(n_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] b;
      logic [7:0] g;
      logic [7:0] r;
      logic       last;
   } pix_t;

   int          checks = 0;
   int          errors = 0;
   pix_t        rx_q[$];
   logic [7:0]  file_q[$];
   bit          toggle_mode = 1'b0;
   bit          use_nc = 1'b0;
   bit          stall = 1'b0;
   logic [31:0] held = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected pixel component k (0=B,1=G,2=R) at row r, column c
   function automatic logic [7:0] pv(input int r, input int c, input int k);
      return 8'(r * 64 + c * 8 + k + 1);
   endfunction

   // Downstream ready: steady 1, or alternating when toggle_mode is set
   always @(negedge clk) begin
      if (toggle_mode) px_ready = ~px_ready;
      else             px_ready = 1'b1;
   end

   // Collect handshaken pixels and check stability during stalls
   always @(negedge clk) begin
      #1;
      if (rst) begin
         stall = 1'b0;
      end else if (px_valid) begin
         if (stall) check("stall_hold", {px_b, px_g, px_r, 7'd0, px_last}, held);
         if (px_ready) rx_q.push_back('{px_b, px_g, px_r, px_last});
         stall = !px_ready;
         held  = {px_b, px_g, px_r, 7'd0, px_last};
      end else begin
         if (stall) check("stall_valid", 32'(px_valid), 32'd1);
         stall = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (use_nc ? n_in_ready : in_ready) begin
            ok = 1'b1;
            @(posedge clk);
            #1;
            break;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!ok) check("send_accept", 32'(ok), 32'd1);
   endtask

   task automatic send_n(input int n);
      for (int i = 0; i < n; i++) send_byte(file_q[i]);
   endtask

   task automatic build(input logic [7:0] s1, input logic [31:0] off, input logic [31:0] w,
                        input logic [31:0] h, input logic [15:0] bpp);
      file_q.delete();
      for (int i = 0; i < 30; i++) file_q.push_back(8'h00);
      file_q[0] = 8'h42;
      file_q[1] = s1;
      for (int k = 0; k < 4; k++) begin
         file_q[10 + k] = 8'(off >> (8 * k));
         file_q[18 + k] = 8'(w >> (8 * k));
         file_q[22 + k] = 8'(h >> (8 * k));
      end
      file_q[26] = 8'h01;
      file_q[28] = bpp[7:0];
      file_q[29] = bpp[15:8];
      for (int i = 30; i < int'(off); i++) file_q.push_back(8'h5A);
      for (int r = 0; r < int'(h); r++) begin
         for (int c = 0; c < int'(w); c++)
            for (int k = 0; k < 3; k++) file_q.push_back(pv(r, c, k));
         if (r < int'(h) - 1)
            for (int p = 0; p < int'(w % 4); p++) file_q.push_back(8'hEE);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rst_flags", {27'd0, px_valid, px_last, hdr_valid, done, err}, 32'd0);
      check("rst_px", {8'd0, px_b, px_g, px_r}, 32'd0);
      check("rst_offset", offset, 32'd0);
      check("rst_width", width, 32'd0);
      check("rst_height", height, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #2;
         if (done) break;
      end
      check("done", 32'(done), 32'd1);
   endtask

   // Stream a whole well-formed image (final row padding omitted) and check the output
   task automatic run_image(input logic [31:0] w, input logic [31:0] h,
                            input logic [31:0] off, input bit tog);
      rx_q.delete();
      toggle_mode = tog;
      build(8'h4D, off, w, h, 16'd24);
      send_n(file_q.size());
      wait_done();
      toggle_mode = 1'b0;
      check("hdr_valid", 32'(hdr_valid), 32'd1);
      check("offset", offset, off);
      check("width", width, w);
      check("height", height, h);
      check("px_count", 32'(rx_q.size()), w * h);
      for (int i = 0; i < rx_q.size(); i++) begin
         int r = i / int'(w);
         int c = i % int'(w);
         check("px_bgr_last", {rx_q[i].b, rx_q[i].g, rx_q[i].r, 7'd0, rx_q[i].last},
               {pv(r, c, 0), pv(r, c, 1), pv(r, c, 2), 7'd0, 1'(i == rx_q.size() - 1)});
      end
      check("end_err", 32'(err), 32'd0);
      check("end_in_ready", 32'(in_ready), 32'd0);
   endtask

   initial begin
      do_reset();

      // 2x2, offset 54: two pad bytes after row 0
      run_image(32'd2, 32'd2, 32'd54, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h33;
      repeat (5) @(negedge clk);
      #2;
      check("post_done_ready", 32'(in_ready), 32'd0);
      check("post_done_pv", 32'(px_valid), 32'd0);
      check("post_done_done", 32'(done), 32'd1);
      in_valid = 1'b0;

      // Bad signature "BN"
      do_reset();
      rx_q.delete();
      build(8'h4E, 32'd54, 32'd2, 32'd2, 16'd24);
      send_n(30);
      @(negedge clk);
      #2;
      check("bn_err", 32'(err), 32'd1);
      check("bn_in_ready", 32'(in_ready), 32'd0);
      check("bn_hdr_valid", 32'(hdr_valid), 32'd0);
      in_valid = 1'b1;
      repeat (6) @(negedge clk);
      in_valid = 1'b0;
      #2;
      check("bn_no_px", 32'(rx_q.size()), 32'd0);
      check("bn_err_held", 32'(err), 32'd1);

      // 3-wide images with stalling downstream, pad 3
      do_reset();
      run_image(32'd3, 32'd1, 32'd54, 1'b1);
      do_reset();
      run_image(32'd3, 32'd2, 32'd54, 1'b1);

      // Zero width: header, skip to offset, done without pixels
      do_reset();
      run_image(32'd0, 32'd5, 32'd40, 1'b0);

      // Reset after G byte of pixel 2, then a full file
      do_reset();
      rx_q.delete();
      build(8'h4D, 32'd54, 32'd2, 32'd2, 16'd24);
      send_n(59);
      @(negedge clk);
      #2;
      check("mid_px1_seen", 32'(rx_q.size()), 32'd1);
      do_reset();
      run_image(32'd2, 32'd2, 32'd54, 1'b0);

      // bpp 32, offset 30, 1x1: checked instance errs, unchecked one streams it
      do_reset();
      use_nc = 1'b1;
      build(8'h4D, 32'd30, 32'd1, 32'd1, 16'd32);
      send_n(33);
      use_nc = 1'b0;
      check("bpp_err", 32'(err), 32'd1);
      check("bpp_hdr_valid", 32'(hdr_valid), 32'd0);
      check("nc_hdr_valid", 32'(n_hdr_valid), 32'd1);
      check("nc_err", 32'(n_err), 32'd0);
      check("nc_px", {7'd0, n_px_valid, n_px_b, n_px_g, n_px_r},
            {7'd0, 1'b1, pv(0, 0, 0), pv(0, 0, 1), pv(0, 0, 2)});
      check("nc_px_last", 32'(n_px_last), 32'd1);
      repeat (2) @(negedge clk);
      #2;
      check("nc_done", 32'(n_done), 32'd1);
      check("nc_pv_clear", 32'(n_px_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute runtime bound
   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
